// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a time
// and buffers fetched instructions in a DEPTH-entry FIFO that feeds decode.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [ILEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_npc
);

    localparam int unsigned     PW      = $clog2(DEPTH);
    localparam logic [PW:0]     DEPTH_C = (PW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP_C  = XLEN'(PC_STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] stale_q, stale_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW:0]     count_q, count_d;
    logic [ILEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];

    logic            req_s;
    logic            xfer_s;
    logic            enq_s;
    logic            deq_s;
    logic [PW:0]     count_next_s;

    // Next-state logic for the request FSM, PC and FIFO pointers.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        stale_d      = stale_q;
        rptr_d       = rptr_q;
        wptr_d       = wptr_q;
        count_d      = count_q;
        req_s        = (state_q == REQ) || (state_q == DROP);
        xfer_s       = req_s && imem_ack;
        enq_s        = (state_q == REQ) && xfer_s && !redirect_valid;
        deq_s        = (count_q != '0) && dec_ready;
        count_next_s = count_q + {{PW{1'b0}}, enq_s} - {{PW{1'b0}}, deq_s};

        if (redirect_valid) begin
            pc_d    = redirect_pc;
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
            // An unanswered request must still complete; remember its address so it stays stable.
            if (req_s && !imem_ack) begin
                state_d = DROP;
                if (state_q == REQ) begin
                    stale_d = pc_q;
                end else begin
                    stale_d = stale_q;
                end
            end else begin
                state_d = REQ;
            end
        end else begin
            count_d = count_next_s;
            if (enq_s) begin
                wptr_d = wptr_q + PW'(1);
            end else begin
                wptr_d = wptr_q;
            end
            if (deq_s) begin
                rptr_d = rptr_q + PW'(1);
            end else begin
                rptr_d = rptr_q;
            end
            case (state_q)
                IDLE: begin
                    if (count_next_s < DEPTH_C) begin
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        pc_d = pc_q + STEP_C;
                        if (count_next_s < DEPTH_C) begin
                            state_d = REQ;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = REQ;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state_d = REQ;
                    end else begin
                        state_d = DROP;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            stale_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stale_q <= stale_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // FIFO storage; contents need no reset because count_q qualifies them.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            instr_mem_q[wptr_q] <= imem_rdata;
            pc_mem_q[wptr_q]    <= pc_q;
        end
    end

    assign imem_req  = req_s && !rst;
    assign imem_addr = (state_q == DROP) ? stale_q : pc_q;
    assign dec_valid = (count_q != '0) && !rst;
    assign dec_instr = rst ? '0 : instr_mem_q[rptr_q];
    assign dec_pc    = rst ? '0 : pc_mem_q[rptr_q];
    assign dec_npc   = dec_pc + STEP_C;

endmodule
